// File: rtl/oric_tap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : oric_tap_pkg                                                  |
// | Purpose   : Shared constants and state encoding for the Oric .TAP image   |
// |             writer (cassette_saver) and its header-byte mux.              |
// | Contents  : TAP byte constants, header field indices, saver state enum.   |
// | Macro     : CASSETTE_SAVER_CHECKSUM_EN adds the ST_CSUM state.            |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package oric_tap_pkg;

  // Fixed bytes of a .TAP image
  localparam logic [7:0] TAP_SYNC       = 8'h16;
  localparam logic [7:0] TAP_MARK       = 8'h24;
  localparam logic [7:0] TAP_AUTORUN    = 8'hC7;
  localparam logic [7:0] TAP_TYPE_BASIC = 8'h00;
  localparam logic [7:0] TAP_TYPE_MC    = 8'h80;

  // Header field positions following the 0x24 marker
  localparam logic [3:0] HDR_RES0     = 4'd0;
  localparam logic [3:0] HDR_RES1     = 4'd1;
  localparam logic [3:0] HDR_TYPE     = 4'd2;
  localparam logic [3:0] HDR_AUTORUN  = 4'd3;
  localparam logic [3:0] HDR_END_HI   = 4'd4;
  localparam logic [3:0] HDR_END_LO   = 4'd5;
  localparam logic [3:0] HDR_START_HI = 4'd6;
  localparam logic [3:0] HDR_START_LO = 4'd7;
  localparam logic [3:0] HDR_PAD      = 4'd8;
  localparam logic [3:0] HDR_LAST     = HDR_PAD;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SYNC  = 4'd1,
    ST_MARK  = 4'd2,
    ST_HDR   = 4'd3,
    ST_NAME  = 4'd4,
    ST_NTERM = 4'd5,
    ST_RD    = 4'd6,
    ST_DATA  = 4'd7,
`ifdef CASSETTE_SAVER_CHECKSUM_EN
    ST_CSUM  = 4'd8,
`endif
    ST_DONE  = 4'd9
  } saver_state_t;

endpackage : oric_tap_pkg
`default_nettype wire

// File: rtl/tap_hdr_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tap_hdr_byte                                                  |
// | Purpose   : Combinational mux returning the .TAP header byte for a given  |
// |             field index from the fields latched at save start.            |
// | Ports     : hdr_idx    in  4   header field index (0..8)                  |
// |             file_type  in  8   program type byte                          |
// |             autorun    in  1   1 -> 0xC7 autorun flag, else 0x00          |
// |             start_addr in 16   first RAM address                          |
// |             end_addr   in 16   last RAM address (inclusive)               |
// |             hdr_byte   out 8   header byte for hdr_idx                    |
// | Macro     : none                                                          |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tap_hdr_byte
  import oric_tap_pkg::*;
(
  input  logic [3:0]  hdr_idx,
  input  logic [7:0]  file_type,
  input  logic        autorun,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  output logic [7:0]  hdr_byte
);

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      HDR_RES0,
      HDR_RES1:     hdr_byte = 8'h00;
      HDR_TYPE:     hdr_byte = file_type;
      HDR_AUTORUN:  hdr_byte = autorun ? TAP_AUTORUN : 8'h00;
      HDR_END_HI:   hdr_byte = end_addr[15:8];
      HDR_END_LO:   hdr_byte = end_addr[7:0];
      HDR_START_HI: hdr_byte = start_addr[15:8];
      HDR_START_LO: hdr_byte = start_addr[7:0];
      HDR_PAD:      hdr_byte = 8'h00;
      default:      hdr_byte = 8'h00;
    endcase
  end

endmodule : tap_hdr_byte
`default_nettype wire

// File: rtl/cassette_saver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : cassette_saver                                                |
// | Purpose   : On a save request, reads an Oric RAM range and streams a      |
// |             complete .TAP image: sync bytes, marker, header, filename,    |
// |             terminator and program body (optional checksum trailer).      |
// | Ports     : clk, reset_n            clock, async active-low reset         |
// |             save_start              one-cycle request (IDLE only)         |
// |             file_type, autorun_en   header type / autorun selection       |
// |             start_addr, end_addr    inclusive RAM range                   |
// |             name_in                 filename, byte 0 in [7:0], NUL ends   |
// |             ram_addr/ram_rd/ram_ack/ram_din   RAM read port            |
// |             out_valid/out_ready/out_data/out_offset/out_last  stream      |
// |             busy, done, error       status                                |
// | Macro     : CASSETTE_SAVER_CHECKSUM_EN appends a mod-256 body sum byte.   |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cassette_saver
  import oric_tap_pkg::*;
#(
  parameter int SYNC_COUNT = 3,   // 1..255
  parameter int NAME_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  save_start,
  input  logic [7:0]            file_type,
  input  logic                  autorun_en,
  input  logic [15:0]           start_addr,
  input  logic [15:0]           end_addr,
  input  logic [8*NAME_LEN-1:0] name_in,
  output logic [15:0]           ram_addr,
  output logic                  ram_rd,
  input  logic                  ram_ack,
  input  logic [7:0]            ram_din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [24:0]           out_offset,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int NIDX_W = (NAME_LEN > 1) ? $clog2(NAME_LEN) : 1;
  localparam logic [7:0]        c_sync_last = 8'(SYNC_COUNT - 1);
  localparam logic [NIDX_W-1:0] c_name_last = NIDX_W'(NAME_LEN - 1);

  saver_state_t r_state;
  saver_state_t w_state_nxt;

  logic [15:0]           r_start;
  logic [15:0]           r_end;
  logic [15:0]           r_addr;
  logic [7:0]            r_type;
  logic                  r_auto;
  logic [8*NAME_LEN-1:0] r_name;     // shifts right one byte per name byte sent
  logic [NIDX_W-1:0]     r_nidx;
  logic [7:0]            r_cnt;      // sync byte count, then header index
  logic [7:0]            r_data;
  logic [24:0]           r_offset;
  logic                  r_error;
`ifdef CASSETTE_SAVER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  logic       w_accept;
  logic       w_reject;
  logic       w_xfer;
  logic       w_at_end;
  logic       w_name_end;
  logic [7:0] w_name_next;
  logic [7:0] w_hdr_byte;

  assign ram_addr   = r_addr;
  assign out_offset = r_offset;
  assign error      = r_error;
  assign w_xfer     = out_valid && out_ready;
  // Compare before increment so an end address of 0xFFFF never wraps
  assign w_at_end   = (r_addr == r_end);

  // Look-ahead at the byte after the one currently on the stream
  generate
    if (NAME_LEN > 1) begin : g_name_next
      assign w_name_next = r_name[15:8];
    end else begin : g_name_single
      assign w_name_next = 8'h00;
    end
  endgenerate

  assign w_name_end = (r_nidx == c_name_last) || (w_name_next == 8'h00);

  tap_hdr_byte u_hdr (
    .hdr_idx    (r_cnt[3:0]),
    .file_type  (r_type),
    .autorun    (r_auto),
    .start_addr (r_start),
    .end_addr   (r_end),
    .hdr_byte   (w_hdr_byte)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and stream/RAM outputs
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    out_last    = 1'b0;
    ram_rd      = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (save_start) begin
          if (end_addr < start_addr) begin
            w_reject = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_SYNC;
          end
        end
      end
      ST_SYNC: begin
        out_valid = 1'b1;
        out_data  = TAP_SYNC;
        if (out_ready && (r_cnt == c_sync_last)) w_state_nxt = ST_MARK;
      end
      ST_MARK: begin
        out_valid = 1'b1;
        out_data  = TAP_MARK;
        if (out_ready) w_state_nxt = ST_HDR;
      end
      ST_HDR: begin
        out_valid = 1'b1;
        out_data  = w_hdr_byte;
        if (out_ready && (r_cnt == {4'b0000, HDR_LAST})) begin
          // An empty name skips straight to the terminator
          w_state_nxt = (r_name[7:0] == 8'h00) ? ST_NTERM : ST_NAME;
        end
      end
      ST_NAME: begin
        out_valid = 1'b1;
        out_data  = r_name[7:0];
        if (out_ready && w_name_end) w_state_nxt = ST_NTERM;
      end
      ST_NTERM: begin
        out_valid = 1'b1;
        out_data  = 8'h00;
        if (out_ready) w_state_nxt = ST_RD;
      end
      ST_RD: begin
        ram_rd = 1'b1;
        if (ram_ack) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        out_valid = 1'b1;
        out_data  = r_data;
`ifdef CASSETTE_SAVER_CHECKSUM_EN
        if (out_ready) w_state_nxt = w_at_end ? ST_CSUM : ST_RD;
`else
        out_last  = w_at_end;
        if (out_ready) w_state_nxt = w_at_end ? ST_DONE : ST_RD;
`endif
      end
`ifdef CASSETTE_SAVER_CHECKSUM_EN
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = r_sum;
        out_last  = 1'b1;
        if (out_ready) w_state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: latched request fields, counters, RAM data and offset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start  <= 16'h0000;
      r_end    <= 16'h0000;
      r_addr   <= 16'h0000;
      r_type   <= 8'h00;
      r_auto   <= 1'b0;
      r_name   <= '0;
      r_nidx   <= '0;
      r_cnt    <= 8'h00;
      r_data   <= 8'h00;
      r_offset <= 25'd0;
      r_error  <= 1'b0;
`ifdef CASSETTE_SAVER_CHECKSUM_EN
      r_sum    <= 8'h00;
`endif
    end else begin
      r_error <= w_reject;

      if (w_xfer) r_offset <= r_offset + 25'd1;

      if (w_accept) begin
        r_start  <= start_addr;
        r_end    <= end_addr;
        r_addr   <= start_addr;
        r_type   <= file_type;
        r_auto   <= autorun_en;
        r_name   <= name_in;
        r_nidx   <= '0;
        r_cnt    <= 8'h00;
        r_offset <= 25'd0;
`ifdef CASSETTE_SAVER_CHECKSUM_EN
        r_sum    <= 8'h00;
`endif
      end

      case (r_state)
        ST_SYNC: begin
          // Counter is reused as the header index once sync is done
          if (w_xfer) r_cnt <= (r_cnt == c_sync_last) ? 8'h00 : r_cnt + 8'd1;
        end
        ST_HDR: begin
          if (w_xfer) r_cnt <= r_cnt + 8'd1;
        end
        ST_NAME: begin
          if (w_xfer) begin
            r_name <= r_name >> 8;
            r_nidx <= r_nidx + 1'b1;
          end
        end
        ST_RD: begin
          if (ram_ack) r_data <= ram_din;
        end
        ST_DATA: begin
          if (w_xfer) begin
`ifdef CASSETTE_SAVER_CHECKSUM_EN
            r_sum <= r_sum + r_data;
`endif
            if (!w_at_end) r_addr <= r_addr + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : cassette_saver
`default_nettype wire
